// File: rtl/img2col_pkg.sv
// Shared types and helpers for the img2col address sequencer.
package img2col_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PRIME  = 2'd1,
    STREAM = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Number of window positions along one axis. A zero stride is rejected at
  // elaboration by the top; returning 1 keeps this function from dividing by zero.
  function automatic int calc_out_dim(input int img, input int k, input int stride);
    if (stride == 0) return 1;
    return (img - k) / stride + 1;
  endfunction

endpackage

// File: rtl/img2col_win_counter.sv
// Nested window counters for the img2col walk. kx is the fastest counter,
// followed by ky, then ox, then oy. Each counter wraps to 0 and carries into
// the next one. The outputs are the carry flags the address datapath needs.
module img2col_win_counter
  import img2col_pkg::*;
#(
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28,
  parameter int K      = 3,
  parameter int STRIDE = 1,
  parameter int CW     = 10
) (
  input  logic clk,
  input  logic nrst,
  input  logic clr,
  input  logic en,
  output logic kx_wrap,
  output logic patch_wrap,
  output logic ox_wrap,
  output logic last_elem
);

  localparam int OUT_W = calc_out_dim(IMG_W, K, STRIDE);
  localparam int OUT_H = calc_out_dim(IMG_H, K, STRIDE);

  localparam logic [CW-1:0] K_LAST  = CW'(K - 1);
  localparam logic [CW-1:0] OX_LAST = CW'(OUT_W - 1);
  localparam logic [CW-1:0] OY_LAST = CW'(OUT_H - 1);

  logic [CW-1:0] kx, ky, ox, oy;
  logic          kx_end, ky_end, ox_end, oy_end;

  assign kx_end = (kx == K_LAST);
  assign ky_end = (ky == K_LAST);
  assign ox_end = (ox == OX_LAST);
  assign oy_end = (oy == OY_LAST);

  assign kx_wrap    = kx_end;
  assign patch_wrap = kx_end && ky_end;
  assign ox_wrap    = patch_wrap && ox_end;
  assign last_elem  = ox_wrap && oy_end;

  // Step the counter nest by one element on each enable; clr returns the nest to the origin.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      kx <= '0;
      ky <= '0;
      ox <= '0;
      oy <= '0;
    end else if (clr) begin
      kx <= '0;
      ky <= '0;
      ox <= '0;
      oy <= '0;
    end else if (en) begin
      if (!kx_end) begin
        kx <= kx + CW'(1);
      end else begin
        kx <= '0;
        if (!ky_end) begin
          ky <= ky + CW'(1);
        end else begin
          ky <= '0;
          if (!ox_end) begin
            ox <= ox + CW'(1);
          end else begin
            ox <= '0;
            oy <= oy_end ? '0 : oy + CW'(1);
          end
        end
      end
    end
  end

endmodule

// File: rtl/img2col_addr_sequencer.sv
// img2col read-address sequencer. After start, it waits PRIME_CYC cycles while
// the array fills. It then streams one linear SRAM address per kernel element,
// in raster order, under a valid/ready handshake.
//
// state  | meaning
// IDLE   | waiting for start
// PRIME  | array fill delay, PRIME_CYC cycles
// STREAM | addr_valid high, advancing on each handshake
// DONE   | one cycle, map_finish pulse
module img2col_addr_sequencer
  import img2col_pkg::*;
#(
  parameter int IMG_W     = 28,
  parameter int IMG_H     = 28,
  parameter int K         = 3,
  parameter int STRIDE    = 1,
  parameter int PRIME_CYC = 160,
  parameter int ADDR_W    = 10
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              start,
  input  logic              abort,
  input  logic              addr_ready,
  output logic              addr_valid,
  output logic [ADDR_W-1:0] addr,
  output logic              patch_last,
  output logic              map_finish,
  output logic              busy
);

  if (K > IMG_W || K > IMG_H || STRIDE == 0) begin : g_bad_geometry
    $error("img2col_addr_sequencer: kernel larger than map or zero stride");
  end
  if (IMG_W * IMG_H > 2 ** ADDR_W) begin : g_bad_addr_w
    $error("img2col_addr_sequencer: ADDR_W too small for IMG_W*IMG_H");
  end

  localparam int PW = (PRIME_CYC > 1) ? $clog2(PRIME_CYC) : 1;
  localparam logic [PW-1:0] PRIME_LAST = PW'((PRIME_CYC > 0) ? PRIME_CYC - 1 : 0);

  localparam logic [ADDR_W-1:0] STRIDE_A = ADDR_W'(STRIDE);
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(STRIDE * IMG_W);
  localparam logic [ADDR_W-1:0] KY_STEP  = ADDR_W'(IMG_W - (K - 1));

  state_t            state_q, state_d;
  logic [PW-1:0]     prime_cnt;
  logic              hs, clr;
  logic              kx_wrap, patch_wrap, ox_wrap, last_elem;
  logic [ADDR_W-1:0] off_q, off_d, win_q, win_d, row_q, row_d, addr_q;

  assign addr_valid = (state_q == STREAM);
  assign busy       = (state_q == PRIME) || (state_q == STREAM);
  assign map_finish = (state_q == DONE);
  assign hs         = addr_valid && addr_ready;
  assign clr        = (state_q != STREAM) || abort;
  assign patch_last = addr_valid && patch_wrap;
  assign addr       = addr_q;

  img2col_win_counter #(
    .IMG_W  (IMG_W),
    .IMG_H  (IMG_H),
    .K      (K),
    .STRIDE (STRIDE),
    .CW     (ADDR_W)
  ) u_win_counter (
    .clk        (clk),
    .nrst       (nrst),
    .clr        (clr),
    .en         (hs),
    .kx_wrap    (kx_wrap),
    .patch_wrap (patch_wrap),
    .ox_wrap    (ox_wrap),
    .last_elem  (last_elem)
  );

  // State register.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic. Abort only has an effect while the sequencer is busy.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (start) state_d = (PRIME_CYC == 0) ? STREAM : PRIME;
      PRIME:  if (abort) state_d = IDLE;
              else if (prime_cnt == PRIME_LAST) state_d = STREAM;
      STREAM: if (abort) state_d = IDLE;
              else if (hs && last_elem) state_d = DONE;
      DONE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Count the cycles spent in PRIME; the count is zero in every other state.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)                          prime_cnt <= '0;
    else if (state_q == PRIME && !abort) prime_cnt <= prime_cnt + PW'(1);
    else                                prime_cnt <= '0;
  end

  // Next address terms. The offset steps within the patch, the window base
  // steps along a row, and the row base steps between rows.
  always_comb begin
    off_d = off_q;
    win_d = win_q;
    row_d = row_q;
    if (!kx_wrap) begin
      off_d = off_q + ADDR_W'(1);
    end else if (!patch_wrap) begin
      off_d = off_q + KY_STEP;
    end else begin
      off_d = '0;
      if (!ox_wrap) begin
        win_d = win_q + STRIDE_A;
      end else if (!last_elem) begin
        row_d = row_q + ROW_STEP;
        win_d = row_q + ROW_STEP;
      end else begin
        row_d = '0;
        win_d = '0;
      end
    end
  end

  // Address registers. They advance only on a handshake and hold while ready is low.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      off_q  <= '0;
      win_q  <= '0;
      row_q  <= '0;
      addr_q <= '0;
    end else if (clr) begin
      off_q  <= '0;
      win_q  <= '0;
      row_q  <= '0;
      addr_q <= '0;
    end else if (hs) begin
      off_q  <= off_d;
      win_q  <= win_d;
      row_q  <= row_d;
      addr_q <= win_d + off_d;
    end
  end

endmodule

// File: tb/tb_img2col_addr_sequencer.sv
// Bench for img2col_addr_sequencer. Two instances share one clock: a 5x5 map
// with K=3 at stride 1, and the same map at stride 2. Addresses are checked
// against an arithmetic model of the window walk.
module tb_img2col_addr_sequencer;

  localparam int W         = 5;
  localparam int H         = 5;
  localparam int KK        = 3;
  localparam int PRIME_CYC = 4;

  logic       clk = 1'b0;
  logic       nrst;
  logic       start[2], abort[2], addr_ready[2];
  logic       addr_valid[2], patch_last[2], map_finish[2], busy[2];
  logic [9:0] addr[2];

  int n_checks = 0;
  int n_pass   = 0;
  int exp_addr[$];
  bit exp_last[$];

  always #5 clk = ~clk;

  img2col_addr_sequencer #(
    .IMG_W(W), .IMG_H(H), .K(KK), .STRIDE(1), .PRIME_CYC(PRIME_CYC), .ADDR_W(10)
  ) u_dut_s1 (
    .clk(clk), .nrst(nrst), .start(start[0]), .abort(abort[0]),
    .addr_ready(addr_ready[0]), .addr_valid(addr_valid[0]), .addr(addr[0]),
    .patch_last(patch_last[0]), .map_finish(map_finish[0]), .busy(busy[0])
  );

  img2col_addr_sequencer #(
    .IMG_W(W), .IMG_H(H), .K(KK), .STRIDE(2), .PRIME_CYC(PRIME_CYC), .ADDR_W(10)
  ) u_dut_s2 (
    .clk(clk), .nrst(nrst), .start(start[1]), .abort(abort[1]),
    .addr_ready(addr_ready[1]), .addr_valid(addr_valid[1]), .addr(addr[1]),
    .patch_last(patch_last[1]), .map_finish(map_finish[1]), .busy(busy[1])
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  // Model of the walk: every window position in raster order, with every kernel element inside it.
  task automatic build_model(input int s);
    int ow, oh;
    ow = (W - KK) / s + 1;
    oh = (H - KK) / s + 1;
    exp_addr.delete();
    exp_last.delete();
    for (int oy = 0; oy < oh; oy++)
      for (int ox = 0; ox < ow; ox++)
        for (int ky = 0; ky < KK; ky++)
          for (int kx = 0; kx < KK; kx++) begin
            exp_addr.push_back((oy * s + ky) * W + ox * s + kx);
            exp_last.push_back(ky == KK - 1 && kx == KK - 1);
          end
  endtask

  // rmode 0: ready always high, 1: pattern 1,0,0 repeating, 2: random.
  task automatic run_map(input int id, input int rmode, input int abort_at, input bit poke);
    int n, lat, idx, cyc, last_seen, n_hs_exp;
    bit r, aborted;
    build_model(id == 0 ? 1 : 2);
    n        = exp_addr.size();
    n_hs_exp = (id == 0) ? 81 : 36;
    @(negedge clk);
    start[id]      = 1'b1;
    addr_ready[id] = 1'b0;
    @(negedge clk);
    start[id] = 1'b0;
    lat = 1;
    chk("busy_in_prime", busy[id], 1);
    chk("valid_in_prime", addr_valid[id], 0);
    while (!addr_valid[id] && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    chk("first_valid_latency", lat, PRIME_CYC + 1);
    idx = 0; cyc = 0; aborted = 0; last_seen = 0;
    while (idx < n && cyc < 4000 && !aborted) begin
      case (rmode)
        0:       r = 1'b1;
        1:       r = (cyc % 3 == 0);
        default: r = 1'($urandom_range(0, 1));
      endcase
      addr_ready[id] = r;
      start[id]      = poke && (cyc == 10);
      chk("valid_held", addr_valid[id], 1);
      chk("addr", addr[id], exp_addr[idx]);
      chk("patch_last", patch_last[id], exp_last[idx]);
      chk("no_finish_in_stream", map_finish[id], 0);
      if (idx == abort_at) begin
        abort[id] = 1'b1;
        aborted   = 1'b1;
      end else if (r) begin
        last_seen = addr[id];
        idx++;
      end
      @(negedge clk);
      cyc++;
    end
    addr_ready[id] = 1'b0;
    start[id]      = 1'b0;
    if (aborted) begin
      abort[id] = 1'b0;
      chk("abort_valid", addr_valid[id], 0);
      chk("abort_busy", busy[id], 0);
      for (int i = 0; i < 4; i++) begin
        chk("abort_no_finish", map_finish[id], 0);
        @(negedge clk);
      end
    end else begin
      chk("handshake_count", idx, n_hs_exp);
      if (id == 1) chk("last_addr_s2", last_seen, 24);
      chk("finish_pulse", map_finish[id], 1);
      chk("done_valid", addr_valid[id], 0);
      chk("done_busy", busy[id], 0);
      @(negedge clk);
      chk("finish_single", map_finish[id], 0);
      chk("idle_busy", busy[id], 0);
    end
  endtask

  // Assert the asynchronous reset between clock edges while instance id is busy.
  task automatic reset_mid(input int id, input int wait_cyc);
    @(negedge clk);
    start[id] = 1'b1;
    @(negedge clk);
    start[id]      = 1'b0;
    addr_ready[id] = 1'b1;
    repeat (wait_cyc) @(negedge clk);
    chk("busy_before_reset", busy[id], 1);
    #2 nrst = 1'b0;
    #1;
    chk("rst_valid", addr_valid[id], 0);
    chk("rst_addr", addr[id], 0);
    chk("rst_patch_last", patch_last[id], 0);
    chk("rst_finish", map_finish[id], 0);
    chk("rst_busy", busy[id], 0);
    @(negedge clk);
    nrst           = 1'b1;
    addr_ready[id] = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    nrst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      start[i] = 1'b0; abort[i] = 1'b0; addr_ready[i] = 1'b0;
    end
    #12;
    for (int i = 0; i < 2; i++) begin
      chk("reset_valid", addr_valid[i], 0);
      chk("reset_addr", addr[i], 0);
      chk("reset_patch_last", patch_last[i], 0);
      chk("reset_finish", map_finish[i], 0);
      chk("reset_busy", busy[i], 0);
    end
    @(negedge clk);
    nrst = 1'b1;

    run_map(0, 0, -1, 1'b0);
    run_map(1, 0, -1, 1'b0);
    run_map(0, 1, -1, 1'b0);
    run_map(1, 1, -1, 1'b0);
    run_map(0, 2, -1, 1'b1);
    run_map(1, 2, -1, 1'b1);
    run_map(0, 0, 20, 1'b0);
    run_map(0, 0, -1, 1'b0);
    run_map(0, 2, int'($urandom_range(0, 80)), 1'b0);
    run_map(1, 2, int'($urandom_range(0, 35)), 1'b0);
    run_map(0, 2, -1, 1'b0);
    reset_mid(0, 2);
    run_map(0, 0, -1, 1'b0);
    reset_mid(0, 12);
    run_map(0, 2, -1, 1'b0);
    reset_mid(1, 9);
    run_map(1, 0, -1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
